// File: rtl/multicycle_stage_ctrl.sv
// Token-passing sequencer for the five-stage multi-cycle CPU (IF/ID/EXE/MEM/WB).
// Optional MC_MEM_SKIP_EN: EXE bypasses MEM when the instruction is not a load/store.
module multicycle_stage_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             IF_over,
  input  logic             ID_over,
  input  logic             EXE_over,
  input  logic             MEM_over,
  input  logic             WB_over,
  input  logic             mem_access,
  output logic             IF_valid,
  output logic             ID_valid,
  output logic             EXE_valid,
  output logic             MEM_valid,
  output logic             WB_valid,
  output logic             IF_ID_en,
  output logic             ID_EXE_en,
  output logic             EXE_MEM_en,
  output logic             MEM_WB_en,
  output logic             next_fetch,
  output logic [2:0]       ctrl_state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt
);

  typedef enum logic [4:0] {
    S_IDLE = 5'b00000,
    S_IF   = 5'b00001,
    S_ID   = 5'b00010,
    S_EXE  = 5'b00100,
    S_MEM  = 5'b01000,
    S_WB   = 5'b10000
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_cnt_q, inst_cnt_q;
  logic             skip_mem;
  logic             run;

`ifdef MC_MEM_SKIP_EN
  assign skip_mem = ~mem_access;
`else
  logic unused_mem_access;
  assign unused_mem_access = mem_access;
  assign skip_mem          = 1'b0;
`endif

  assign IF_valid  = state_q[0];
  assign ID_valid  = state_q[1];
  assign EXE_valid = state_q[2];
  assign MEM_valid = state_q[3];
  assign WB_valid  = state_q[4];

  // Enables are masked by reset so an in-flight handshake cannot latch a bus while resetting.
  assign run        = ~reset;
  assign IF_ID_en   = run & IF_valid  & IF_over;
  assign ID_EXE_en  = run & ID_valid  & ID_over;
  assign EXE_MEM_en = run & EXE_valid & EXE_over;
  assign MEM_WB_en  = run & ((MEM_valid & MEM_over) | (EXE_valid & EXE_over & skip_mem));
  assign next_fetch = run & WB_valid  & WB_over;

  assign cycle_cnt = cycle_cnt_q;
  assign inst_cnt  = inst_cnt_q;

  always_comb begin
    state_d    = state_q;
    ctrl_state = 3'd0;
    unique case (state_q)
      S_IDLE: begin
        ctrl_state = 3'd0;
        if (!hold) state_d = S_IF;
      end
      S_IF: begin
        ctrl_state = 3'd1;
        if (IF_over) state_d = S_ID;
      end
      S_ID: begin
        ctrl_state = 3'd2;
        if (ID_over) state_d = S_EXE;
      end
      S_EXE: begin
        ctrl_state = 3'd3;
        if (EXE_over) state_d = skip_mem ? S_WB : S_MEM;
      end
      S_MEM: begin
        ctrl_state = 3'd4;
        if (MEM_over) state_d = S_WB;
      end
      S_WB: begin
        ctrl_state = 3'd5;
        if (WB_over) state_d = hold ? S_IDLE : S_IF;
      end
      default: begin
        state_d    = S_IDLE;
        ctrl_state = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cycle_cnt_q <= '0;
      inst_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (next_fetch) inst_cnt_q <= inst_cnt_q + CNT_W'(1);
    end
  end

endmodule
